// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-side controller of the clock-domain-crossing FIFO
//
// Ports:
//   clk, rst_n   read-domain clock, asynchronous active-low reset
//   wptr_gray    Gray write pointer from the write domain (asynchronous to clk)
//   ram_ra       RAM read address
//   ram_rd       RAM read data, combinational from ram_ra
//   rptr_gray    registered Gray read pointer returned to the write domain
//   empty        no unread entries left in the RAM (output register not counted)
//   rd_count     RAM-side occupancy, 0..(1<<addrsize)
//   dout         show-ahead output data register
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout when dout_valid && dout_ready

module fifo_read_ctrl #(
  parameter int MSB      = 8,
  parameter int addrsize = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [addrsize:0]   wptr_gray,
  output logic [addrsize-1:0] ram_ra,
  input  logic [MSB-1:0]      ram_rd,
  output logic [addrsize:0]   rptr_gray,
  output logic                empty,
  output logic [addrsize:0]   rd_count,
  output logic [MSB-1:0]      dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  logic [addrsize:0] wq1;
  logic [addrsize:0] wq2;
  logic [addrsize:0] wbin_s;
  logic [addrsize:0] rbin;
  logic [addrsize:0] rgray;
  logic [addrsize:0] rbin_next;
  logic [addrsize:0] rgray_next;
  logic              pop;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= addrsize; i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  // Pop whenever the RAM has data and the output register is free or being drained
  // this same cycle, which sustains one word per clock.
  assign pop        = !empty && (!dout_valid || dout_ready);
  assign rbin_next  = rbin + {{addrsize{1'b0}}, pop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  assign ram_ra    = rbin[addrsize-1:0];
  assign rptr_gray = rgray;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq1        <= '0;
      wq2        <= '0;
      rbin       <= '0;
      rgray      <= '0;
      empty      <= 1'b1;
      rd_count   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      // Two-flop synchronizer; only wq2 is used by any downstream logic.
      wq1      <= wptr_gray;
      wq2      <= wq1;
      rbin     <= rbin_next;
      rgray    <= rgray_next;
      // Full-width compare: the extra wrap bit distinguishes full from empty.
      empty    <= (rgray_next == wq2);
      // One extra bit lets a full RAM read as 1<<addrsize rather than 0.
      rd_count <= wbin_s - rbin_next;
      if (pop) begin
        dout       <= ram_rd;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed self-checking bench for fifo_read_ctrl

module tb_fifo_read_ctrl;

  localparam int MSB      = 8;
  localparam int addrsize = 4;

  logic                clk;
  logic                rst_n;
  logic [addrsize:0]   wptr_gray;
  logic [addrsize-1:0] ram_ra;
  logic [MSB-1:0]      ram_rd;
  logic [addrsize:0]   rptr_gray;
  logic                empty;
  logic [addrsize:0]   rd_count;
  logic [MSB-1:0]      dout;
  logic                dout_valid;
  logic                dout_ready;

  logic [MSB-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  assign ram_rd = mem[ram_ra];

  fifo_read_ctrl #(.MSB(MSB), .addrsize(addrsize)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wptr_gray  (wptr_gray),
    .ram_ra     (ram_ra),
    .ram_rd     (ram_rd),
    .rptr_gray  (rptr_gray),
    .empty      (empty),
    .rd_count   (rd_count),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    wptr_gray  = '0;
    dout_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n      = 1'b0;
    wptr_gray  = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state with the clock running.
    tick(3);
    check("rst_empty", empty, 1);
    check("rst_valid", dout_valid, 0);
    check("rst_rptr", rptr_gray, 0);
    check("rst_count", rd_count, 0);
    check("rst_dout", dout, 0);
    rst_n = 1'b1;
    tick(1);

    // Latency: one word at address 0.
    mem[0]    = 8'h11;
    wptr_gray = 5'h01;
    tick(2);
    check("lat_empty_e2", empty, 1);
    tick(1);
    check("lat_empty_e3", empty, 0);
    check("lat_valid_e3", dout_valid, 0);
    check("lat_count_e3", rd_count, 1);
    tick(1);
    check("lat_dout_e4", dout, 8'h11);
    check("lat_valid_e4", dout_valid, 1);
    check("lat_last_empty", empty, 1);
    check("lat_last_count", rd_count, 0);
    check("lat_rptr", rptr_gray, 5'h01);
    dout_ready = 1'b1;
    tick(1);
    check("lat_drained_valid", dout_valid, 0);
    check("lat_drained_dout", dout, 8'h11);

    // Streaming: five words at one per clock.
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
    dout_ready = 1'b1;
    wptr_gray  = 5'h07;
    tick(3);
    check("str_count", rd_count, 5);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("str_data", dout, 32'hA0 + k);
      check("str_valid", dout_valid, 1);
    end
    check("str_empty", empty, 1);
    check("str_count_end", rd_count, 0);
    check("str_rptr", rptr_gray, 5'h07);
    tick(1);
    check("str_valid_end", dout_valid, 0);

    // Backpressure: three words, consumer stalled.
    do_reset();
    mem[0] = 8'h31; mem[1] = 8'h32; mem[2] = 8'h33;
    wptr_gray = 5'h02;
    tick(7);
    check("bp_dout", dout, 8'h31);
    check("bp_valid", dout_valid, 1);
    check("bp_count", rd_count, 2);
    check("bp_rptr", rptr_gray, 5'h01);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    check("bp_dout2", dout, 8'h32);
    check("bp_count2", rd_count, 1);
    check("bp_rptr2", rptr_gray, 5'h03);
    tick(2);
    check("bp_hold", dout, 8'h32);

    // Reset mid-stream, asserted away from the clock edge.
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'h50 + 8'(i);
    wptr_gray = 5'h06;
    tick(4);
    check("mrst_pre_valid", dout_valid, 1);
    check("mrst_pre_count", rd_count, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", dout_valid, 0);
    check("mrst_dout", dout, 0);
    check("mrst_empty", empty, 1);
    check("mrst_rptr", rptr_gray, 0);
    check("mrst_count", rd_count, 0);
    wptr_gray = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Full RAM and pointer wrap across two fills.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
    wptr_gray = 5'h18;
    tick(3);
    check("full_count", rd_count, 16);
    check("full_empty", empty, 0);
    dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("fill1_ra", ram_ra, k);
      tick(1);
      check("fill1_data", dout, 32'h40 + k);
    end
    check("fill1_rptr", rptr_gray, 5'h18);
    check("fill1_ra_end", ram_ra, 0);
    check("fill1_empty", empty, 1);
    for (int i = 0; i < 16; i++) mem[i] = 8'h60 + 8'(i);
    wptr_gray = 5'h00;
    tick(3);
    check("full2_count", rd_count, 16);
    for (int k = 0; k < 16; k++) begin
      check("fill2_ra", ram_ra, k);
      tick(1);
      check("fill2_data", dout, 32'h60 + k);
    end
    check("wrap_rptr", rptr_gray, 5'h00);
    check("wrap_ra", ram_ra, 0);
    check("wrap_empty", empty, 1);
    check("wrap_count", rd_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
